// File: rtl/rx_ipv4.sv
// IPv4 receive stage: validates the header, filters on destination and protocol,
// strips the header and options, and forwards exactly the payload bytes.
module rx_ipv4 #(
  parameter int unsigned    OCT   = 8,
  parameter logic [OCT-1:0] PROTO = OCT'(8'h11)
) (
  input  logic               RX_CLK,
  input  logic               rst,
  input  logic [OCT*4-1:0]   ip_addr,
  input  logic               rx_data_v,
  input  logic [OCT-1:0]     rx_data,
  output logic               rx_ipv4_data_v,
  output logic [OCT-1:0]     rx_ipv4_data,
  output logic [OCT*4-1:0]   rx_src_ip,
  output logic [OCT*2-1:0]   rx_ipv4_len,
  output logic               rx_ipv4_irq
);

  localparam int unsigned WW = 2 * OCT;
  localparam int unsigned AW = 4 * OCT;
  localparam int unsigned CW = WW;

  typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [WW-1:0] acc;
  logic [OCT-1:0] hi;
  logic [3:0]    ver;
  logic [3:0]    ihl;
  logic [WW-1:0] tot_len;
  logic          mf;
  logic [12:0]   frag_off;
  logic [OCT-1:0] proto;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic          idle_seen;
  logic          irq_pend;

  logic [CW-1:0] hdr_len;
  logic          hdr_last;
  logic [WW:0]   sum17;
  logic [WW-1:0] acc_nxt;
  logic [AW-1:0] dst_c;
  logic [WW-1:0] pay_len;
  logic          accept;

  // Header decode; the final header byte is folded in combinationally
  always_comb begin
    hdr_len  = CW'({ihl, 2'b00});
    hdr_last = (cnt != '0) && (cnt == hdr_len - CW'(1));
    sum17    = {1'b0, acc} + {1'b0, hi, rx_data};
    acc_nxt  = sum17[WW-1:0] + WW'(sum17[WW]);
    dst_c    = (ihl == 4'd5) ? {dst[AW-OCT-1:0], rx_data} : dst;
    pay_len  = tot_len - hdr_len;
    accept   = (ver == 4'd4) && (ihl >= 4'd5)
             && (acc_nxt == {WW{1'b1}})
             && (proto == PROTO)
             && !mf && (frag_off == 13'd0)
             && (tot_len >= hdr_len)
             && ((dst_c == ip_addr) || (dst_c == {AW{1'b1}}));
  end

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      state          <= HDR;
      cnt            <= '0;
      acc            <= '0;
      hi             <= '0;
      ver            <= '0;
      ihl            <= '0;
      tot_len        <= '0;
      mf             <= 1'b0;
      frag_off       <= '0;
      proto          <= '0;
      src            <= '0;
      dst            <= '0;
      idle_seen      <= 1'b0;
      irq_pend       <= 1'b0;
      rx_ipv4_data_v <= 1'b0;
      rx_ipv4_data   <= '0;
      rx_src_ip      <= '0;
      rx_ipv4_len    <= '0;
      rx_ipv4_irq    <= 1'b0;
    end else begin
      rx_ipv4_data_v <= 1'b0;
      rx_ipv4_irq    <= irq_pend;
      irq_pend       <= 1'b0;

      if (!rx_data_v) begin
        state     <= HDR;
        cnt       <= '0;
        acc       <= '0;
        idle_seen <= 1'b1;
      end else if (idle_seen) begin
        // A frame interrupted by reset is ignored until the line goes idle
        case (state)
          HDR: begin
            cnt <= cnt + CW'(1);
            if (cnt[0]) acc <= acc_nxt;
            else        hi  <= rx_data;

            case (cnt)
              CW'(0): begin
                ver <= rx_data[7:4];
                ihl <= rx_data[3:0];
                if (rx_data[7:4] != 4'd4 || rx_data[3:0] < 4'd5) state <= DROP;
              end
              CW'(2):  tot_len[WW-1:OCT] <= rx_data;
              CW'(3):  tot_len[OCT-1:0]  <= rx_data;
              CW'(6): begin
                mf              <= rx_data[5];
                frag_off[12:8]  <= rx_data[4:0];
              end
              CW'(7):  frag_off[7:0] <= rx_data;
              CW'(9):  proto <= rx_data;
              CW'(12), CW'(13), CW'(14), CW'(15): src <= {src[AW-OCT-1:0], rx_data};
              CW'(16), CW'(17), CW'(18), CW'(19): dst <= {dst[AW-OCT-1:0], rx_data};
              default: ;
            endcase

            if (hdr_last) begin
              cnt <= '0;
              if (accept) begin
                rx_src_ip   <= src;
                rx_ipv4_len <= pay_len;
                if (pay_len == '0) begin
                  rx_ipv4_irq <= 1'b1;
                  state       <= DROP;
                end else begin
                  state <= PAYLOAD;
                end
              end else begin
                state <= DROP;
              end
            end
          end

          PAYLOAD: begin
            rx_ipv4_data   <= rx_data;
            rx_ipv4_data_v <= 1'b1;
            cnt            <= cnt + CW'(1);
            // Trailing Ethernet pad falls into DROP and is never forwarded
            if (cnt == rx_ipv4_len - CW'(1)) begin
              state    <= DROP;
              irq_pend <= 1'b1;
            end
          end

          DROP: ;

          default: state <= DROP;
        endcase
      end
    end
  end

endmodule

// File: doc/rx_ipv4.md
Name: rx_ipv4

Overview:
- Receive-path IPv4 stage between the Ethernet-frame stage (EtherType 0x0800, MAC header already stripped) and the UDP stage.
- Parses and validates the IPv4 header, filters on destination address and protocol, and strips the header and any options.
- Forwards exactly the IP payload bytes as a contiguous valid-qualified byte stream.
- Raises a one-cycle completion pulse consumed by the UDP stage.

Parameters:
- OCT, 8, byte width.
- PROTO, 8'h11, accepted IP protocol number.

Ports:
- RX_CLK  input  1  receive clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ip_addr  input  OCT*4  local IPv4 address.
- rx_data_v  input  1  high for every byte of one IP datagram (plus Ethernet pad); low between frames.
- rx_data  input  OCT  datagram byte, network order.
- rx_ipv4_data_v  output  1  payload byte valid.
- rx_ipv4_data  output  OCT  payload byte.
- rx_src_ip  output  OCT*4  source address of the current accepted datagram.
- rx_ipv4_len  output  OCT*2  payload length = total_length - IHL*4.
- rx_ipv4_irq  output  1  one-cycle pulse: accepted datagram fully delivered.

Behaviour:
- Reset values: rx_ipv4_data_v=0, rx_ipv4_irq=0, rx_ipv4_data=0, rx_src_ip=0, rx_ipv4_len=0. State=HDR, byte counter=0, checksum accumulator=0.
- Reset mid-frame: immediately drop everything. Bytes from the rest of that frame are ignored until rx_data_v has been low for at least one cycle.
- State HDR (bytes 0..IHL*4-1):
  - Byte counter increments per valid byte.
  - Latch version/IHL (byte 0), total_length (bytes 2-3), flags/fragment offset (bytes 6-7), protocol (byte 9), source IP (bytes 12-15, shift-in MSB first), destination IP (bytes 16-19). Option bytes are counted and checksummed only.
  - Checksum: pair bytes into 16-bit words (even byte high). Accumulate into 17 bits, folding the carry back in (end-around) every word.
- Accept decision, evaluated in the cycle the final header byte arrives (that byte included combinationally). Accept iff all of:
  - version==4 and IHL>=5
  - folded sum==16'hFFFF
  - protocol==PROTO
  - MF==0 and fragment offset==0
  - total_length >= IHL*4
  - destination == ip_addr or 32'hFFFFFFFF
- On accept:
  - Update rx_src_ip and rx_ipv4_len on that clock edge.
  - If payload length==0, pulse irq the next cycle and go to DROP.
  - Otherwise go to PAYLOAD.
- On reject: go to DROP. rx_src_ip and rx_ipv4_len are held at their previous values.
- PAYLOAD:
  - Each valid input byte is registered to rx_ipv4_data with rx_ipv4_data_v=1. Latency is exactly 1 cycle.
  - Payload counter counts to rx_ipv4_len.
  - After the last payload byte: go to DROP. In the following cycle rx_ipv4_data_v=0 and rx_ipv4_irq=1 for exactly one cycle.
  - Ethernet pad bytes are never forwarded.
- DROP: ignore bytes; rx_ipv4_data_v=0.
- Any state, rx_data_v low:
  - Return to HDR, clear counters and accumulator, rx_ipv4_data_v=0 next cycle.
  - If the frame ended before the declared payload length (truncated): no irq.
- Back-to-back frames need one idle cycle of rx_data_v=0 between them. irq from frame N and byte 0 of frame N+1 may coincide; both are handled.
- rx_ipv4_data_v never toggles within a payload. This is required because the UDP stage treats a low valid as end-of-datagram.

Test Plan:
1. Accept with exact payload length. Header 45 00 00 20 00 00 40 00 40 11 B7 79 C0 A8 01 01 C0 A8 01 02, ip_addr=C0A80102, 12 payload bytes 00..0B.
   - rx_ipv4_data_v high for exactly 12 cycles starting 1 cycle after payload byte 0, data 00..0B.
   - rx_ipv4_len=0x000C, rx_src_ip=C0A80101.
   - rx_ipv4_irq is one pulse on the cycle after byte 0B is output.
2. Same datagram with checksum byte B7 changed to B8, and separately with ip_addr=C0A80103 → no rx_ipv4_data_v, no irq, rx_src_ip unchanged.
3. Case 1 followed by 6 pad bytes before rx_data_v falls → still exactly 12 output bytes and one irq; pad not forwarded.
4. IHL=6, header with 4 option bytes and recomputed checksum, total_length 0x24 → option bytes not forwarded; 12 payload bytes forwarded; rx_ipv4_len=12.
5. Case 1 with rx_data_v dropped after payload byte 5 → 6 bytes output, then valid low, no irq. The next full frame after one idle cycle is accepted normally.
6. Assert rst during payload byte 3 of case 1 → outputs at reset values the next cycle. The remainder of the frame is not forwarded and no irq occurs. The following frame is accepted.
